// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
// Shared constants and helpers for the parametrised UART FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count.
//   cnt_width()            : width of the fill-level counter (0..DEPTH inclusive).
//   err_bit_e              : bit positions of the sticky error flags in a status register.
package uart_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Counter must represent every value 0..depth, hence depth+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [0:0] {
        ERR_OVF_BIT = 1'b0,
        ERR_UDF_BIT = 1'b1
    } err_bit_e;

endpackage

// File: rtl/uart_fifo_sync_param_if.sv
// uart_fifo_sync_param_if
// Host-side bundle of the FIFO: write/read handshakes, control strobes,
// status flags and fill level.
//   master : the side that writes/reads the FIFO (host / testbench).
//   slave  : the FIFO itself.
interface uart_fifo_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    import uart_fifo_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_ack;
    logic              flush;
    logic              clr_err;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output wr_en, wr_data, rd_en, flush, clr_err,
        input  rd_data, rd_valid, wr_ack, full, empty, almost_full, almost_empty,
               count, overflow, underflow, err_ovf, err_udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, flush, clr_err,
        output rd_data, rd_valid, wr_ack, full, empty, almost_full, almost_empty,
               count, overflow, underflow, err_ovf, err_udf
    );

endinterface

// File: rtl/uart_fifo_ptr.sv
// uart_fifo_ptr
// Modulo-DEPTH pointer; DEPTH need not be a power of two, so the wrap is an
// explicit compare against DEPTH-1 rather than natural binary overflow.
//   clk, rst_n : clock, synchronous active-low reset.
//   clr        : synchronous return to 0 (flush).
//   inc        : advance by one entry.
//   ptr        : current pointer value.
module uart_fifo_ptr #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register with explicit wrap at the last entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (clr) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= (ptr_r == LAST) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/uart_fifo_sync_param.sv
// uart_fifo_sync_param
// Synchronous FIFO of arbitrary depth for the UART datapath, with fill level,
// programmable almost-full/almost-empty thresholds, synchronous flush, one-cycle
// overflow/underflow pulses and sticky error flags.
// Ports:
//   clk, rst_n : single clock, synchronous active-low reset.
//   bus        : uart_fifo_sync_param_if.slave (wr/rd handshakes, flush, clr_err,
//                flags, count, error pulses and sticky errors).
// Build option:
//   UART_FIFO_FWFT_EN defined   -> first-word-fall-through: rd_data shows the head
//                                  word combinationally, rd_valid = !empty.
//   UART_FIFO_FWFT_EN undefined -> rd_data/rd_valid registered, one cycle after a pop.
module uart_fifo_sync_param
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_fifo_sync_param_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic              full_s;
    logic              empty_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic              wr_ack_r;
    logic              ovf_r;
    logic              udf_r;
    logic              err_ovf_r;
    logic              err_udf_r;

    // Accept decisions; flush suppresses every transfer in its cycle, and a
    // write into a full FIFO is allowed when a read frees a slot at the same edge.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == CNT_W'(0));
        rd_acc_s  = bus.rd_en & ~empty_s & ~bus.flush;
        wr_acc_s  = bus.wr_en & (~full_s | rd_acc_s) & ~bus.flush;
        ovf_set_s = bus.wr_en & ~wr_acc_s & ~bus.flush;
        udf_set_s = bus.rd_en & ~rd_acc_s & ~bus.flush;
    end

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (wr_acc_s),
        .ptr   (wr_ptr_s)
    );

    uart_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .inc   (rd_acc_s),
        .ptr   (rd_ptr_s)
    );

    // Fill level: a simultaneous accepted read and write leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
        end else if (bus.flush) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_s] <= bus.wr_data;
        end
    end

    // Write acknowledge, error pulses and sticky errors (a new error beats clr_err).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack_r  <= 1'b0;
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else begin
            wr_ack_r  <= wr_acc_s;
            ovf_r     <= ovf_set_s;
            udf_r     <= udf_set_s;
            err_ovf_r <= ovf_set_s | (err_ovf_r & ~bus.clr_err);
            err_udf_r <= udf_set_s | (err_udf_r & ~bus.clr_err);
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is always on display; a pop simply advances the read pointer.
    always_comb begin
        bus.rd_data  = mem_r[rd_ptr_s];
        bus.rd_valid = ~empty_s;
    end
`else
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // Registered read port: data is captured on the accepted pop and held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= mem_r[rd_ptr_s];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    always_comb begin
        bus.rd_data  = rd_data_r;
        bus.rd_valid = rd_valid_r;
    end
`endif

    // Status outputs; threshold flags derive from the registered count.
    always_comb begin
        bus.full         = full_s;
        bus.empty        = empty_s;
        bus.almost_full  = (count_r >= CNT_W'(AF_LEVEL));
        bus.almost_empty = (count_r <= CNT_W'(AE_LEVEL));
        bus.count        = count_r;
        bus.wr_ack       = wr_ack_r;
        bus.overflow     = ovf_r;
        bus.underflow    = udf_r;
        bus.err_ovf      = err_ovf_r;
        bus.err_udf      = err_udf_r;
    end

endmodule

// File: tb/tb_uart_fifo_sync_param.sv
// tb_uart_fifo_sync_param
// Self-checking bench for uart_fifo_sync_param at DEPTH=10, AF_LEVEL=8, AE_LEVEL=2.
// A queue-based reference model predicts every output each cycle; directed
// sequences add literal expectations, then a randomized phase follows.
// Honours UART_FIFO_FWFT_EN the same way as the design.
module tb_uart_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 10;
    localparam int AF     = 8;
    localparam int AE     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_fifo_sync_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [7:0] q[$];
    logic [7:0] m_rd_data  = 8'h00;
    logic       m_rd_valid = 1'b0;
    logic       m_wr_ack   = 1'b0;
    logic       m_ovf      = 1'b0;
    logic       m_udf      = 1'b0;
    logic       m_eovf     = 1'b0;
    logic       m_eudf     = 1'b0;

    initial begin : model_compare
        bit ra, wa, ovf_set, udf_set;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_rd_data = 8'h00; m_rd_valid = 1'b0; m_wr_ack = 1'b0;
                m_ovf = 1'b0; m_udf = 1'b0; m_eovf = 1'b0; m_eudf = 1'b0;
            end else if (bus.flush) begin
                q.delete();
                m_rd_valid = 1'b0; m_wr_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
                if (bus.clr_err) begin
                    m_eovf = 1'b0; m_eudf = 1'b0;
                end
            end else begin
                ra = bus.rd_en && (q.size() > 0);
                wa = bus.wr_en && ((q.size() < DEPTH) || ra);
                ovf_set = bus.wr_en && !wa;
                udf_set = bus.rd_en && !ra;
                if (ra) m_rd_data = q.pop_front();
                if (wa) q.push_back(bus.wr_data);
                m_rd_valid = ra;
                m_wr_ack   = wa;
                m_ovf      = ovf_set;
                m_udf      = udf_set;
                m_eovf     = ovf_set || (m_eovf && !bus.clr_err);
                m_eudf     = udf_set || (m_eudf && !bus.clr_err);
            end
            @(negedge clk);
            check("count",        bus.count,        q.size());
            check("full",         bus.full,         q.size() == DEPTH);
            check("empty",        bus.empty,        q.size() == 0);
            check("almost_full",  bus.almost_full,  q.size() >= AF);
            check("almost_empty", bus.almost_empty, q.size() <= AE);
            check("wr_ack",       bus.wr_ack,       m_wr_ack);
            check("overflow",     bus.overflow,     m_ovf);
            check("underflow",    bus.underflow,    m_udf);
            check("err_ovf",      bus.err_ovf,      m_eovf);
            check("err_udf",      bus.err_udf,      m_eudf);
`ifdef UART_FIFO_FWFT_EN
            check("rd_valid",     bus.rd_valid,     q.size() > 0);
            if (q.size() > 0) check("rd_data", bus.rd_data, q[0]);
`else
            check("rd_valid",     bus.rd_valid,     m_rd_valid);
            check("rd_data",      bus.rd_data,      m_rd_data);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit r,
                         input bit f = 1'b0, input bit c = 1'b0);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.flush   = f;
        bus.clr_err = c;
        step();
    endtask

    initial begin : stimulus
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0;
        bus.flush = 1'b0; bus.clr_err = 1'b0;

        // Reset
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        check("rst_count", bus.count, 32'd0);
        check("rst_empty", bus.empty, 32'd1);
        check("rst_rd_valid", bus.rd_valid, 32'd0);

        // Fill to full, then one rejected write
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 8'(i), 1'b0);
        check("fill_full", bus.full, 32'd1);
        check("fill_count", bus.count, 32'd10);
        drive(1'b1, 8'h0B, 1'b0);
        check("ovf_wr_ack", bus.wr_ack, 32'd0);
        check("ovf_pulse", bus.overflow, 32'd1);
        check("ovf_sticky", bus.err_ovf, 32'd1);

        // Drain: order 0x01..0x0A
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
            check("drain_data", bus.rd_data, 32'(i));
            drive(1'b0, 8'h00, 1'b1);
`else
            drive(1'b0, 8'h00, 1'b1);
            check("drain_data", bus.rd_data, 32'(i));
            check("drain_valid", bus.rd_valid, 32'd1);
`endif
        end
        check("drain_empty", bus.empty, 32'd1);

        // Full boundary: simultaneous read+write accepted
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        check("fullrw_count", bus.count, 32'd10);
        check("fullrw_ovf", bus.overflow, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_FIFO_FWFT_EN
            if (i == DEPTH - 1) check("fullrw_last", bus.rd_data, 32'h55);
            drive(1'b0, 8'h00, 1'b1);
`else
            drive(1'b0, 8'h00, 1'b1);
            if (i == DEPTH - 1) check("fullrw_last", bus.rd_data, 32'h55);
`endif
        end

        // Empty boundary: write accepted, read rejected
        drive(1'b1, 8'h33, 1'b1);
        check("emptyrw_count", bus.count, 32'd1);
        check("emptyrw_udf", bus.underflow, 32'd1);
`ifdef UART_FIFO_FWFT_EN
        check("emptyrw_data", bus.rd_data, 32'h33);
        drive(1'b0, 8'h00, 1'b1);
`else
        drive(1'b0, 8'h00, 1'b1);
        check("emptyrw_data", bus.rd_data, 32'h33);
`endif

        // Pointer wrap with interleaved pairs
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            check("wrap_count_max", bus.count <= 1, 32'd1);
            drive(1'b0, 8'h00, 1'b1);
        end

        // Threshold sweep 0..10
        for (int k = 0; k <= DEPTH; k++) begin
            check("ae_level", bus.almost_empty, 32'(k <= AE));
            check("af_level", bus.almost_full, 32'(k >= AF));
            if (k < DEPTH) drive(1'b1, 8'(k), 1'b0);
        end

        // Flush with a concurrent write, then clear errors
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_count", bus.count, 32'd0);
        check("flush_empty", bus.empty, 32'd1);
        check("flush_no_ack", bus.wr_ack, 32'd0);
        check("flush_keeps_sticky", bus.err_ovf, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_err_ovf", bus.err_ovf, 32'd0);
        check("clr_err_udf", bus.err_udf, 32'd0);

        // Reset mid-fill
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
        drive(1'b1, 8'h01, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 8'h99, 1'b0);
        check("midrst_count", bus.count, 32'd0);
        check("midrst_empty", bus.empty, 32'd1);
        check("midrst_wr_ack", bus.wr_ack, 32'd0);
        check("midrst_rd_valid", bus.rd_valid, 32'd0);
`ifndef UART_FIFO_FWFT_EN
        check("midrst_rd_data", bus.rd_data, 32'd0);
`endif
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

`ifdef UART_FIFO_FWFT_EN
        // Fall-through visibility and same-cycle pop
        drive(1'b1, 8'hA5, 1'b0);
        check("fwft_valid", bus.rd_valid, 32'd1);
        check("fwft_data", bus.rd_data, 32'hA5);
        drive(1'b1, 8'h5A, 1'b0);
        bus.rd_en = 1'b1; bus.wr_en = 1'b0;
        #1;
        check("fwft_pop_shows", bus.rd_data, 32'hA5);
        step();
        check("fwft_next", bus.rd_data, 32'h5A);
        drive(1'b0, 8'h00, 1'b1);
`endif

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(0, 255) != 0);
            drive(1'($urandom_range(0, 99) < 55), 8'($urandom),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 15) == 0));
        end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
